aes128_out_serializer: RTL and testbench
========================================

# aes128_out_serializer

Downstream companion to the Aes128 core: watches the core's `ready` and 128-bit `out`, captures each finished block into a small block FIFO, and streams it out as bytes over a valid/ready handshake. It decouples the core's one-block-at-a-time result from a byte-wide consumer such as a UART or DMA packer. It also flags any result lost to back-pressure.

## Interface
- `DEPTH`, 2: block FIFO depth in 128-bit entries; power of two, ≥ 2.
- `DROP_W`, 8: width of the dropped-block counter.

- `clk`  in  1: single clock; all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `aes_ready`  in  1: Aes128 `ready`; level, high while `aes_out` is valid.
- `aes_out`  in  128: Aes128 `out`.
- `m_data`  out  8: current output byte.
- `m_valid`  out  1: `m_data` valid.
- `m_ready`  in  1: consumer accepts the byte when high with `m_valid`.
- `m_last`  out  1: high with the 16th byte of a block.
- `overflow`  out  1: sticky; set when a block is dropped.
- `drop_count`  out  DROP_W: saturating count of dropped blocks.

## Operation
- Capture trigger:
  - `rdy_q` is a registered copy of `aes_ready`, reset to 0.
  - A capture event is `aes_ready & ~rdy_q`, the 0→1 edge.
  - `aes_ready` already high when reset releases counts as one event.
  - A level held high produces exactly one capture.
- Capture pushes `aes_out` into the FIFO tail at that clock edge.
- Capture is accepted when the FIFO is not full, or when it is full and the final byte of the head block pops in the same cycle (pop-then-push).
- Otherwise the block is dropped:
  - `overflow` is set to 1.
  - `drop_count` increments and saturates at all-ones.
  - FIFO contents are unchanged.
- Byte order is MSB first: byte 0 = `aes_out[127:120]`, byte 15 = `aes_out[7:0]`.
- Serializer:
  - 4-bit byte index `idx` into the head entry.
  - `m_data` = head byte `idx`.
  - `m_valid` = FIFO non-empty.
  - `m_last` = `m_valid & (idx == 15)`.
- Transfer occurs on `m_valid & m_ready`:
  - `idx` increments.
  - At `idx == 15` it wraps to 0 and the head entry pops.
- With `m_valid` high and `m_ready` low, `m_data`, `m_last` and `idx` hold stable (AXI-stream rules).
- Reset values:
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0x00.
  - `overflow` = 0, `drop_count` = 0.
  - FIFO empty, `idx` = 0, `rdy_q` = 0.
- Reset mid-operation is asynchronous: all queued and partially sent blocks are discarded, and no byte is emitted after `reset_n` falls.
- `overflow` and `drop_count` clear only on reset.

## Timing
- Capture at edge k gives `m_valid` = 1 and byte 0 on `m_data` after edge k when the FIFO was empty. Latency is 1 cycle from the cycle `aes_ready` is first seen high.
- Throughput is 1 byte/cycle with `m_ready` held high, i.e. 16 cycles per block.
- Back-to-back blocks emit with no bubble: byte 15 of block n is followed by byte 0 of block n+1 in the next cycle.
- `m_data`, `m_valid`, `m_last` come from registered state through a byte mux only; there is no combinational path from `m_ready` or `aes_*` to any output.
- A simultaneous capture and pop on an empty FIFO cannot occur: pop requires a non-empty FIFO.
- Full-FIFO pointer wrap uses a `log2(DEPTH)+1`-bit pointer compare.

## Structure
- `aes128_pkg` holds `AES_BLOCK_BITS` = 128, `AES_BLOCK_BYTES` = 16 and the typedef `aes_block_t` (logic [127:0]), shared with Aes128 and future mode wrappers.
- Sub-module `aes128_block_fifo`: synchronous FIFO of `aes_block_t`, parameter `DEPTH`.
  - Signals: `push`, `pop`, `full`, `empty`, `head`.
  - Same-cycle push and pop when full is allowed.
- The top level contains edge detection, drop accounting and the byte-index serializer.

## Test plan
- Single block: hold `m_ready` = 1; raise `aes_ready` with `aes_out` = 0x000102…0F. Expect `m_data` 0x00..0x0F on 16 consecutive cycles, `m_last` only on 0x0F, then `m_valid` = 0.
- Back-pressure: toggle `m_ready` 1,0,0,1,…. Each byte stays stable while stalled, the sequence is unchanged, and no byte is duplicated or skipped.
- Level hold: keep `aes_ready` high for 40 cycles. Exactly one block (16 bytes) is emitted.
- Overflow: `m_ready` = 0; produce 3 rising edges with distinct blocks A, B, C. Expect `overflow` = 1 and `drop_count` = 1. After releasing `m_ready`, A then B are emitted and C is absent.
- Pop-then-push: FIFO full, consumer on byte 15 of the head. A rising edge in that same cycle is accepted, and `overflow` stays 0.
- Reset mid-stream: assert `reset_n` = 0 at byte 7 of a block. `m_valid` drops immediately. After release with `aes_ready` = 0, nothing is emitted and the counters read 0.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: block width constants, the block type and a
// byte-extraction helper used by anything that serializes a block.
// No ports; imported with `import aes128_pkg::*;`.
package aes128_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

  // Byte idx of a block, MSB first: idx 0 -> blk[127:120], idx 15 -> blk[7:0].
  function automatic logic [7:0] block_byte(input aes_block_t blk, input logic [3:0] idx);
    aes_block_t sh;
    sh = blk << {idx, 3'b000};
    return sh[AES_BLOCK_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/aes128_block_fifo.sv
// Synchronous FIFO of aes_block_t entries.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset (pointers only)
//   push, wr_data      : write request and block to enqueue
//   pop                : remove head entry
//   full, empty        : status
//   head               : current head entry (valid while !empty)
// A push while full is accepted only when a pop happens in the same cycle.
module aes128_block_fifo
  import aes128_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  aes_block_t wr_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output aes_block_t head
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  aes_block_t  mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; emptiness is tracked by the pointers.
  // On pop-then-push when full the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/aes128_out_serializer.sv
// Captures each finished AES-128 block (rising edge of aes_ready) into a
// block FIFO and streams it out MSB-first as bytes over valid/ready.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   aes_ready, aes_out  : core result strobe (level) and 128-bit result
//   m_data, m_valid     : output byte stream
//   m_ready             : consumer accept
//   m_last              : marks byte 15 of a block
//   overflow            : sticky, a block was dropped on a full FIFO
//   drop_count          : saturating count of dropped blocks
module aes128_out_serializer
  import aes128_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              aes_ready,
  input  logic [127:0]      aes_out,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              rdy_q,      rdy_d;
  logic [3:0]        idx_q,      idx_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q,     drop_d;

  logic       fifo_full;
  logic       fifo_empty;
  aes_block_t fifo_head;

  logic capture;
  logic xfer;
  logic pop;
  logic push_ok;

  // A level-high aes_ready yields one capture; rdy_q resets to 0 so a level
  // already high at reset release also counts.
  assign capture = aes_ready & ~rdy_q;
  assign xfer    = m_valid & m_ready;
  assign pop     = xfer & (idx_q == 4'd15);
  assign push_ok = capture & (~fifo_full | pop);

  always_comb begin
    rdy_d      = aes_ready;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (xfer) idx_d = idx_q + 4'd1;  // wraps 15 -> 0 together with the pop
    if (capture && !push_ok) begin
      overflow_d = 1'b1;
      drop_d     = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      idx_q      <= 4'd0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  aes128_block_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_ok),
    .wr_data(aes_out),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Outputs depend only on registered state; m_data is forced to zero while
  // empty so stale storage never shows up on the bus.
  assign m_valid    = ~fifo_empty;
  assign m_last     = ~fifo_empty & (idx_q == 4'd15);
  assign m_data     = fifo_empty ? 8'h00 : block_byte(fifo_head, idx_q);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_aes128_out_serializer.sv
module tb_aes128_out_serializer;

  logic         clk;
  logic         reset_n;
  logic         aes_ready;
  logic [127:0] aes_out;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         overflow;
  logic [7:0]   drop_count;

  int checks = 0;
  int errors = 0;

  aes128_out_serializer #(
    .DEPTH (2),
    .DROP_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .aes_ready (aes_ready),
    .aes_out   (aes_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block whose byte i (MSB first) is base+i.
  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] base);
    aes_out   = mk(base);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; aes_ready = 1'b0; aes_out = '0; m_ready = 1'b0;
    step(); step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %0b exp 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %02h exp 00", m_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
    reset_n = 1'b1;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %0b exp 0", m_valid); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    aes_out = mk(8'h00);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i) || m_last !== (i == 15)) begin
        errors++;
        $display("FAIL single_byte%0d got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b",
                 i, m_valid, m_data, m_last, 8'(i), (i == 15));
      end
      step();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_done_valid got %0b exp 0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] prev;
    int n = 0;
    int cyc = 0;
    m_ready = 1'b0;
    aes_out = mk(8'h40);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    prev = m_data;
    while (n < 16 && cyc < 100) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h40 + 8'(n) || m_last !== (n == 15)) begin
        errors++;
        $display("FAIL bp_byte%0d got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b",
                 n, m_valid, m_data, m_last, 8'h40 + 8'(n), (n == 15));
      end
      m_ready = pat[cyc % 4];
      step();
      if (m_ready) n++;
      cyc++;
    end
    m_ready = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL bp_timeout got %0d bytes exp 16", n); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %0b exp 0", m_valid); end
  endtask

  task automatic test_level_hold();
    int cnt = 0;
    m_ready = 1'b1;
    aes_out = mk(8'h80);
    aes_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (m_valid) cnt++;
    end
    aes_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (m_valid) cnt++;
    end
    checks++; if (cnt != 16) begin errors++; $display("FAIL level_hold_bytes got %0d exp 16", cnt); end
  endtask

  task automatic test_pop_push();
    m_ready = 1'b0;
    capture(8'h10);
    capture(8'h20);
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++; if (m_data !== 8'h1F || m_last !== 1'b1) begin errors++; $display("FAIL pp_head_last got d=%02h l=%0b exp d=1f l=1", m_data, m_last); end
    aes_out = mk(8'h30);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got %0b exp 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL pp_drop_count got %0d exp 0", drop_count); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== ((i < 16) ? 8'h20 : 8'h30) + 8'(i % 16) || m_last !== (i % 16 == 15)) begin
        errors++;
        $display("FAIL pp_byte%0d got v=%0b d=%02h l=%0b exp v=1 d=%02h l=%0b",
                 i, m_valid, m_data, m_last, ((i < 16) ? 8'h20 : 8'h30) + 8'(i % 16), (i % 16 == 15));
      end
      step();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pp_done_valid got %0b exp 0", m_valid); end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    capture(8'h50);
    capture(8'h60);
    capture(8'h70);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL ovf_drop_count got %0d exp 1", drop_count); end
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== ((i < 16) ? 8'h50 : 8'h60) + 8'(i % 16)) begin
        errors++;
        $display("FAIL ovf_byte%0d got v=%0b d=%02h exp v=1 d=%02h",
                 i, m_valid, m_data, ((i < 16) ? 8'h50 : 8'h60) + 8'(i % 16));
      end
      step();
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_c_absent got v=%0b d=%02h exp v=0", m_valid, m_data); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    m_ready = 1'b1;
    aes_out = mk(8'h90);
    aes_ready = 1'b1;
    step();
    aes_ready = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++; if (m_data !== 8'h97) begin errors++; $display("FAIL rst_mid_pos got %02h exp 97", m_data); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b exp 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %02h exp 00", m_data); end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_emitted got %0d cycles exp 0", seen); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow got %0b exp 0", overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_mid_drop_count got %0d exp 0", drop_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_level_hold();
    test_pop_push();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
